// File: rtl/regfile_sb.sv
// Multi-port register file: 31 GPRs + HI/LO, per-register busy scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to reads.

module regfile_sb_rport #(
  parameter int NW    = 4,
  parameter int NHILO = 2
) (
  input  logic [5:0]           raddr,
  input  logic [31:0][31:0]    gpr,
  input  logic [63:0]          hilo,
  input  logic [32:0]          busy,
`ifdef REGFILE_BYPASS_EN
  input  logic [NW-1:0]        we,
  input  logic [NW-1:0][5:0]   waddr,
  input  logic [NW-1:0][63:0]  wdata,
`endif
  output logic [63:0]          rdata,
  output logic                 rbusy
);

  always_comb begin
    rdata = '0;
    rbusy = 1'b0;
    if (!raddr[5]) begin
      rdata = {32'b0, gpr[raddr[4:0]]};
      rbusy = busy[raddr[4:0]];
    end else if (raddr == 6'd32) begin
      rdata = hilo;
      rbusy = busy[32];
    end
`ifdef REGFILE_BYPASS_EN
    // ascending scan: the youngest matching port is the last to assign
    for (int p = 0; p < NW; p++) begin
      if (we[p] && waddr[p] == raddr && raddr != 6'd0 &&
          (!raddr[5] || (raddr == 6'd32 && p < NHILO))) begin
        rdata = raddr[5] ? wdata[p] : {32'b0, wdata[p][31:0]};
        rbusy = 1'b0;
      end
    end
`endif
  end

endmodule

module regfile_sb #(
  parameter int NR    = 16,
  parameter int NW    = 4,
  parameter int NHILO = 2,
  parameter int NI    = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NR*6-1:0]   raddr,
  output logic [NR*64-1:0]  rdata,
  output logic [NR-1:0]     rbusy,
  input  logic [NW-1:0]     we,
  input  logic [NW*6-1:0]   waddr,
  input  logic [NW*64-1:0]  wdata,
  input  logic [NI-1:0]     iss_v,
  input  logic [NI*6-1:0]   iss_addr,
  input  logic              flush
);

  logic [NW-1:0][5:0]  wa;
  logic [NW-1:0][63:0] wd;
  logic [NI-1:0][5:0]  ia;
  logic [NR-1:0][5:0]  ra;
  logic [NR-1:0][63:0] rd;

  assign wa = waddr;
  assign wd = wdata;
  assign ia = iss_addr;
  assign ra = raddr;
  assign rdata = rd;

  // entry 0 of gpr/busy is kept as a constant-zero flop so reads index directly
  logic [31:0][31:0] gpr_q, gpr_d;
  logic [63:0]       hilo_q, hilo_d;
  logic [32:0]       busy_q, busy_d;

  always_comb begin
    gpr_d  = gpr_q;
    hilo_d = hilo_q;
    busy_d = busy_q;
    for (int p = 0; p < NW; p++) begin
      if (we[p]) begin
        if (!wa[p][5] && wa[p][4:0] != 5'd0) begin
          gpr_d[wa[p][4:0]]  = wd[p][31:0];
          busy_d[wa[p][4:0]] = 1'b0;
        end else if (wa[p] == 6'd32 && p < NHILO) begin
          hilo_d     = wd[p];
          busy_d[32] = 1'b0;
        end
      end
    end
    // issues are younger than the writes retiring this cycle, so set after clear
    for (int k = 0; k < NI; k++) begin
      if (iss_v[k]) begin
        if (!ia[k][5])            busy_d[ia[k][4:0]] = 1'b1;
        else if (ia[k] == 6'd32)  busy_d[32]         = 1'b1;
      end
    end
    if (flush) busy_d = '0;
    gpr_d[0]  = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gpr_q  <= '0;
      hilo_q <= '0;
      busy_q <= '0;
    end else begin
      gpr_q  <= gpr_d;
      hilo_q <= hilo_d;
      busy_q <= busy_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // no forwarding while held in reset: outputs must read as zero
  logic [NW-1:0] we_byp;
  assign we_byp = resetn ? we : '0;
`endif

  for (genvar i = 0; i < NR; i++) begin : g_rp
    regfile_sb_rport #(.NW(NW), .NHILO(NHILO)) u_rp (
      .raddr (ra[i]),
      .gpr   (gpr_q),
      .hilo  (hilo_q),
      .busy  (busy_q),
`ifdef REGFILE_BYPASS_EN
      .we    (we_byp),
      .waddr (wa),
      .wdata (wd),
`endif
      .rdata (rd[i]),
      .rbusy (rbusy[i])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, corner sequences,
// and randomized traffic against an array-based reference model.

module tb_regfile_sb;
  localparam int NR = 16, NW = 4, NHILO = 2, NI = 2;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NR*6-1:0]   raddr;
  logic [NR*64-1:0]  rdata;
  logic [NR-1:0]     rbusy;
  logic [NW-1:0]     we;
  logic [NW*6-1:0]   waddr;
  logic [NW*64-1:0]  wdata;
  logic [NI-1:0]     iss_v;
  logic [NI*6-1:0]   iss_addr;
  logic              flush;

  regfile_sb #(.NR(NR), .NW(NW), .NHILO(NHILO), .NI(NI)) dut (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .iss_v(iss_v), .iss_addr(iss_addr),
    .flush(flush)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  logic [63:0] m_reg  [0:63];
  logic        m_busy [0:63];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int a = 0; a < 64; a++) begin m_reg[a] = '0; m_busy[a] = 1'b0; end
  endtask

  function automatic bit legal_w(int p, int a);
    return (a >= 1 && a <= 31) || (a == 32 && p < NHILO);
  endfunction

  task automatic commit();
    for (int p = 0; p < NW; p++) begin
      int a = int'(waddr[6*p +: 6]);
      if (we[p] && legal_w(p, a)) begin
        m_reg[a]  = (a == 32) ? wdata[64*p +: 64] : {32'b0, wdata[64*p +: 32]};
        m_busy[a] = 1'b0;
      end
    end
    for (int k = 0; k < NI; k++) begin
      int a = int'(iss_addr[6*k +: 6]);
      if (iss_v[k] && a >= 1 && a <= 32) m_busy[a] = 1'b1;
    end
    if (flush) for (int a = 0; a < 64; a++) m_busy[a] = 1'b0;
  endtask

  function automatic logic [63:0] exp_rd(int a);
    logic [63:0] v;
    if (!resetn) return '0;
    v = (a >= 1 && a <= 32) ? m_reg[a] : 64'd0;
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < NW; p++)
      if (we[p] && int'(waddr[6*p +: 6]) == a && legal_w(p, a))
        v = (a == 32) ? wdata[64*p +: 64] : {32'b0, wdata[64*p +: 32]};
`endif
    return v;
  endfunction

  function automatic logic exp_bz(int a);
    logic b;
    if (!resetn) return 1'b0;
    b = (a >= 1 && a <= 32) ? m_busy[a] : 1'b0;
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < NW; p++)
      if (we[p] && int'(waddr[6*p +: 6]) == a && legal_w(p, a)) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; iss_v = '0; iss_addr = '0; flush = 1'b0; raddr = '0;
  endtask

  task automatic set_w(input int p, input logic [5:0] a, input logic [63:0] d);
    we[p] = 1'b1; waddr[6*p +: 6] = a; wdata[64*p +: 64] = d;
  endtask

  task automatic set_i(input int k, input logic [5:0] a);
    iss_v[k] = 1'b1; iss_addr[6*k +: 6] = a;
  endtask

  // commit model on the edge, return at the following falling edge
  task automatic tick();
    @(posedge clk);
    if (resetn) commit();
    @(negedge clk);
  endtask

  task automatic check_ports(input string nm);
    for (int i = 0; i < NR; i++) begin
      int a = int'(raddr[6*i +: 6]);
      chk($sformatf("%s_rd%0d", nm, i), rdata[64*i +: 64], exp_rd(a));
      chk($sformatf("%s_bz%0d", nm, i), {63'b0, rbusy[i]}, {63'b0, exp_bz(a)});
    end
  endtask

  typedef struct {
    int          wp;
    logic        wen;
    logic [5:0]  wa;
    logic [63:0] wd;
    logic        iv;
    logic [5:0]  ia;
    logic        fl;
    logic [5:0]  ra;
    logic [63:0] ed;
    logic        eb;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{0, 1'b1, 6'd5,  64'h1234,                1'b0, 6'd0,  1'b0, 6'd5,  64'h1234,                1'b0};
    tbl[1]  = '{0, 1'b0, 6'd0,  64'h0,                   1'b1, 6'd4,  1'b0, 6'd4,  64'h0,                   1'b1};
    tbl[2]  = '{1, 1'b1, 6'd4,  64'h44,                  1'b1, 6'd4,  1'b0, 6'd4,  64'h44,                  1'b1};
    tbl[3]  = '{2, 1'b1, 6'd4,  64'h45,                  1'b0, 6'd0,  1'b0, 6'd4,  64'h45,                  1'b0};
    tbl[4]  = '{3, 1'b1, 6'd0,  64'hFFFF,                1'b0, 6'd0,  1'b0, 6'd0,  64'h0,                   1'b0};
    tbl[5]  = '{1, 1'b1, 6'd32, 64'h11112222_33334444,   1'b0, 6'd0,  1'b0, 6'd32, 64'h11112222_33334444,   1'b0};
    tbl[6]  = '{3, 1'b1, 6'd32, 64'hDEAD,                1'b0, 6'd0,  1'b0, 6'd32, 64'h11112222_33334444,   1'b0};
    tbl[7]  = '{0, 1'b1, 6'd40, 64'h77,                  1'b0, 6'd0,  1'b0, 6'd40, 64'h0,                   1'b0};
    tbl[8]  = '{0, 1'b0, 6'd0,  64'h0,                   1'b1, 6'd40, 1'b0, 6'd40, 64'h0,                   1'b0};
    tbl[9]  = '{0, 1'b1, 6'd10, 64'hFFFFFFFF_000000AB,   1'b0, 6'd0,  1'b0, 6'd10, 64'h0000_0000_0000_00AB, 1'b0};
    tbl[10] = '{0, 1'b0, 6'd0,  64'h0,                   1'b1, 6'd3,  1'b0, 6'd3,  64'h0,                   1'b1};
    tbl[11] = '{0, 1'b0, 6'd0,  64'h0,                   1'b1, 6'd6,  1'b0, 6'd6,  64'h0,                   1'b1};
    tbl[12] = '{0, 1'b0, 6'd0,  64'h0,                   1'b1, 6'd8,  1'b1, 6'd8,  64'h0,                   1'b0};

    resetn = 1'b0;
    idle();
    model_clear();
    @(negedge clk);
    for (int i = 0; i < NR; i++) raddr[6*i +: 6] = 6'(i);
    #1 check_ports("rst");
    tick();
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      idle();
      if (tbl[i].wen) set_w(tbl[i].wp, tbl[i].wa, tbl[i].wd);
      if (tbl[i].iv)  set_i(i % NI, tbl[i].ia);
      flush = tbl[i].fl;
      tick();
      idle();
      raddr[5:0] = tbl[i].ra;
      #1;
      chk($sformatf("vec%0d_rd", i), rdata[63:0], tbl[i].ed);
      chk($sformatf("vec%0d_bz", i), {63'b0, rbusy[0]}, {63'b0, tbl[i].eb});
    end

    // flush also cleared r3 and r6 set earlier
    raddr[11:6] = 6'd3; raddr[17:12] = 6'd6;
    #1;
    chk("flush_r3", {63'b0, rbusy[1]}, 64'd0);
    chk("flush_r6", {63'b0, rbusy[2]}, 64'd0);

    // write conflict: youngest port wins on every read port
    tick();
    idle();
    set_w(0, 6'd7, 64'hAAAA);
    set_w(3, 6'd7, 64'h5555);
    tick();
    idle();
    for (int i = 0; i < NR; i++) raddr[6*i +: 6] = 6'd7;
    #1;
    for (int i = 0; i < NR; i++) chk($sformatf("conflict_p%0d", i), rdata[64*i +: 64], 64'h5555);

    // same-cycle read-after-write on r9 with r9 busy
    tick();
    idle();
    set_w(0, 6'd9, 64'h1);
    set_i(0, 6'd9);
    tick();
    idle();
    set_w(2, 6'd9, 64'hCAFE);
    raddr[5:0] = 6'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_rd", rdata[63:0], 64'hCAFE);
    chk("byp_bz", {63'b0, rbusy[0]}, 64'd0);
`else
    chk("byp_rd", rdata[63:0], 64'h1);
    chk("byp_bz", {63'b0, rbusy[0]}, 64'd1);
`endif
    tick();
    idle();
    raddr[5:0] = 6'd9;
    #1;
    chk("byp_next_rd", rdata[63:0], 64'hCAFE);
    chk("byp_next_bz", {63'b0, rbusy[0]}, 64'd0);

    // mid-run reset: r5 busy and holding data, write attempted during reset
    tick();
    idle();
    set_i(1, 6'd5);
    tick();
    idle();
    resetn = 1'b0;
    model_clear();
    set_w(0, 6'd5, 64'h9999);
    for (int i = 0; i < NR; i++) raddr[6*i +: 6] = 6'd5;
    #1;
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("mrst_rd%0d", i), rdata[64*i +: 64], 64'd0);
      chk($sformatf("mrst_bz%0d", i), {63'b0, rbusy[i]}, 64'd0);
    end
    tick();
    idle();
    resetn = 1'b1;
    raddr[5:0] = 6'd5;
    #1;
    chk("mrst_after_rd", rdata[63:0], 64'd0);
    chk("mrst_after_bz", {63'b0, rbusy[0]}, 64'd0);
    tick();

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int p = 0; p < NW; p++) begin
        we[p] = 1'($urandom_range(0, 1));
        waddr[6*p +: 6] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(32, 40))
                                                       : 6'($urandom_range(0, 12));
        wdata[64*p +: 64] = {$urandom, $urandom};
      end
      for (int k = 0; k < NI; k++) begin
        iss_v[k] = 1'($urandom_range(0, 1));
        iss_addr[6*k +: 6] = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(32, 40))
                                                         : 6'($urandom_range(0, 12));
      end
      flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NR; i++)
        raddr[6*i +: 6] = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(32, 40))
                                                      : 6'($urandom_range(0, 12));
      #1 check_ports($sformatf("rnd%0d", c));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
